// File: rtl/sword_serial_shift_out.sv
// sword_serial_shift_out: loads a frame, shifts it out on a divided clock for a 74HC595-style chain, then strobes the latch.
module sword_serial_shift_out #(
  parameter int DATA_W    = 64,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset_N,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sr_clk,
  output logic              sr_do,
  output logic              sr_pen,
  output logic              sr_clr_n
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  logic [1:0]        st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_adv;
  logic              clk_q, clk_d, do_q, do_d, pen_q, pen_d;
  logic              busy_q, busy_d, done_q, done_d, clr_q;
  logic              first_bit, adv_bit, div_last;
  assign sh_adv    = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
  assign adv_bit   = MSB_FIRST ? sh_adv[DATA_W-1] : sh_adv[0];
  assign first_bit = MSB_FIRST ? data_i[DATA_W-1] : data_i[0];
  assign div_last  = div_q == DIV_LAST;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    sh_d   = sh_q;
    clk_d  = clk_q;
    do_d   = do_q;
    pen_d  = pen_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (st_q)
      IDLE: begin
        clk_d  = 1'b0;
        pen_d  = !load_i;
        busy_d = load_i;
        if (load_i) begin
          st_d  = SHIFT;
          sh_d  = data_i;
          cnt_d = '0;
          div_d = '0;
          do_d  = first_bit;
        end
      end
      SHIFT: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        clk_d = div_last ? !clk_q : clk_q;
        // End of the high phase: advance to the next bit or finish the frame.
        if (div_last && clk_q) begin
          sh_d  = sh_adv;
          cnt_d = cnt_q + 1'b1;
          do_d  = (cnt_q == BIT_LAST) ? 1'b0 : adv_bit;
          st_d  = (cnt_q == BIT_LAST) ? LATCH : SHIFT;
        end
      end
      LATCH: begin
        div_d  = div_last ? '0 : div_q + 1'b1;
        st_d   = div_last ? IDLE : LATCH;
        pen_d  = div_last;
        done_d = div_last;
        busy_d = !div_last;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      div_q  <= '0;
      sh_q   <= '0;
      clk_q  <= 1'b0;
      do_q   <= 1'b0;
      pen_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sh_q   <= sh_d;
      clk_q  <= clk_d;
      do_q   <= do_d;
      pen_q  <= pen_d;
      busy_q <= busy_d;
      done_q <= done_d;
      clr_q  <= 1'b1;
    end
  end
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign sr_clk   = clk_q;
  assign sr_do    = do_q;
  assign sr_pen   = pen_q;
  assign sr_clr_n = clr_q;
endmodule

// File: tb/tb_sword_serial_shift_out.sv
// tb_sword_serial_shift_out: three configurations (16/2/MSB, 16/2/LSB, 8/1/MSB) checked against a bit-order and latency model.
module tb_sword_serial_shift_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] d [3];
  logic [2:0] ld = '0;
  logic [2:0] busy, done, sclk, sdo, pen, clrn;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sword_serial_shift_out #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_m (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .data_i(d[0]), .load_i(ld[0]),
    .busy_o(busy[0]), .done_o(done[0]), .sr_clk(sclk[0]), .sr_do(sdo[0]),
    .sr_pen(pen[0]), .sr_clr_n(clrn[0]));
  sword_serial_shift_out #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_l (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .data_i(d[1]), .load_i(ld[1]),
    .busy_o(busy[1]), .done_o(done[1]), .sr_clk(sclk[1]), .sr_do(sdo[1]),
    .sr_pen(pen[1]), .sr_clr_n(clrn[1]));
  sword_serial_shift_out #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_s (
    .SI_ClkIn(clk), .SI_Reset_N(rst_n), .data_i(d[2][7:0]), .load_i(ld[2]),
    .busy_o(busy[2]), .done_o(done[2]), .sr_clk(sclk[2]), .sr_do(sdo[2]),
    .sr_pen(pen[2]), .sr_clr_n(clrn[2]));
  function automatic int wof(input int k);
    return k == 2 ? 8 : 16;
  endfunction
  function automatic int cdof(input int k);
    return k == 2 ? 1 : 2;
  endfunction
  // Serial order expected on the wire; the first bit sent lands in bit w-1.
  function automatic logic [15:0] order(input logic [15:0] dv, input int k);
    logic [15:0] o = '0;
    int w = wof(k);
    for (int i = 0; i < w; i++) o[w-1-i] = (k == 1) ? dv[i] : dv[w-1-i];
    return o;
  endfunction
  function automatic int lat_of(input int k);
    return 1 + 2 * cdof(k) * wof(k) + cdof(k);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic start(input int k, input logic [15:0] dv);
    @(negedge clk);
    d[k] = dv;
    ld[k] = 1'b1;
  endtask
  task automatic watch(input int k, input logic [15:0] exp, input int lat, input int inj,
                       input bit chain, input logic [15:0] nd);
    int c = 0, rises = 0, last = 0;
    int w = wof(k), cd = cdof(k);
    logic [15:0] cap = '0;
    logic [15:0] mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    logic pc = 1'b0, pd = 1'b0, hold = 1'b0;
    bit ok_busy = 1, ok_stab = 1, ok_per = 1, ok_pen = 1, got = 0;
    while (!got && c < 500) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        if (!(inj > 0 && inj == 1)) ld[k] = 1'b0;
        chk("busy_first_cycle", {31'd0, busy[k]}, 1);
      end
      if (inj > 0 && c == inj) begin ld[k] = 1'b1; d[k] = 16'hFFFF; end
      if (inj > 0 && c == inj + 1) ld[k] = 1'b0;
      if (sclk[k] && !pc) begin
        rises++;
        cap = {cap[14:0], sdo[k]};
        hold = sdo[k];
        if (sdo[k] !== pd) ok_stab = 0;
        if (rises > 1 && c - last != 2 * cd) ok_per = 0;
        last = c;
      end else if (sclk[k] && sdo[k] !== hold) ok_stab = 0;
      if (!done[k] && (busy[k] !== 1'b1 || pen[k] !== 1'b0)) begin ok_busy = 0; ok_pen = 0; end
      pc = sclk[k];
      pd = sdo[k];
      if (done[k]) begin
        got = 1;
        chk("done_latency", c, lat);
        chk("bits", {16'd0, cap & mask}, {16'd0, exp});
        chk("rise_count", rises, w);
        chk("busy_pen_during", {31'd0, ok_busy & ok_pen}, 1);
        chk("do_stable", {31'd0, ok_stab}, 1);
        chk("clk_period", {31'd0, ok_per}, 1);
        chk("done_busy_pen", {30'd0, busy[k], pen[k]}, 32'b01);
        if (chain) begin ld[k] = 1'b1; d[k] = nd; end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask
  typedef struct {
    int k;
    logic [15:0] dv;
    logic [15:0] exp;
    int lat;
  } vec_t;
  vec_t tv [4];
  initial begin
    int k, rises, hits;
    logic pc;
    logic [15:0] dv;
    tv[0] = '{0, 16'hA5C3, 16'hA5C3, 67};
    tv[1] = '{1, 16'hA5C3, 16'hC3A5, 67};
    tv[2] = '{2, 16'h0081, 16'h0081, 18};
    tv[3] = '{1, 16'h0001, 16'h8000, 67};
    for (int i = 0; i < 3; i++) d[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_state", {26'd0, pen[i], sclk[i], clrn[i], busy[i], done[i], sdo[i]}, 32'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_release", {29'd0, clrn}, 32'b111);
    for (int i = 0; i < 4; i++) begin
      start(tv[i].k, tv[i].dv);
      watch(tv[i].k, tv[i].exp, tv[i].lat, 0, 0, 16'h0);
      @(negedge clk);
      chk("idle_after", {30'd0, done[tv[i].k], pen[tv[i].k]}, 32'b01);
    end
    start(0, 16'h1234);
    watch(0, order(16'h1234, 0), lat_of(0), 20, 1, 16'h0001);
    watch(0, order(16'h0001, 0), lat_of(0), 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 2);
      dv = 16'($urandom);
      if (k == 2) dv = dv & 16'h00FF;
      start(k, dv);
      watch(k, order(dv, k), lat_of(k), (i % 2 == 1) ? 9 : 0, 0, 16'h0);
    end
    start(0, 16'hA5C3);
    rises = 0;
    pc = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      ld[0] = 1'b0;
      if (sclk[0] && !pc) rises++;
      pc = sclk[0];
      if (rises == 7 && !sclk[0]) break;
    end
    chk("reached_bit7", rises, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_midframe", {26'd0, pen[0], sclk[0], clrn[0], busy[0], done[0], sdo[0]}, 32'b100000);
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (sclk[0] || done[0] || busy[0]) hits++;
    end
    chk("no_activity_after_reset", hits, 0);
    chk("clr_after_reset", {31'd0, clrn[0]}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
